// File: rtl/cpu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pipe_pkg
//
// Shared pipeline types for the EX/MEM area of the core.
//
// Contents:
//   XLEN, REG_ADDR_W  default datapath and register-tag widths
//   alu_entry_t       one EX->MEM entry at the default XLEN width
//   flags_t           architectural NZCV flags
//   FLAGS_RESET       flag register value after reset
//   flags_to_nzcv     packs flags_t into a 4-bit {N,Z,C,V} vector
// ---------------------------------------------------------------------------
package cpu_pipe_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    // One entry travelling from EX to MEM, at the default datapath width.
    // Stages built at other widths declare the same field order locally.
    typedef struct packed {
        logic [XLEN-1:0]       result;
        logic                  carry;
        logic                  overflow;
        logic                  set_flags;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  valid;
    } alu_entry_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam flags_t FLAGS_RESET = '0;

    function automatic logic [3:0] flags_to_nzcv(input flags_t f);
        return {f.n, f.z, f.c, f.v};
    endfunction

endpackage

// File: rtl/alu_result_stage_flag_calc.sv
// ---------------------------------------------------------------------------
// flag_calc
//
// Combinational NZCV computation for one ALU result. Also used by the
// branch unit, so it carries no state and no pipeline knowledge.
//
// Parameters:
//   WIDTH     width of the result word
// Ports:
//   result    ALU result word
//   carry     adder carry-out, passed through as C
//   overflow  adder signed overflow, passed through as V
//   flags     N = result MSB, Z = result is zero, C, V
// ---------------------------------------------------------------------------
module flag_calc
    import cpu_pipe_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] result,
    input  logic             carry,
    input  logic             overflow,
    output flags_t           flags
);

    // N and Z derive from the result word; C and V come straight from the
    // adder because only the adder knows the unsigned/signed wrap.
    always_comb begin
        flags   = FLAGS_RESET;
        flags.n = result[WIDTH-1];
        flags.z = (result == '0);
        flags.c = carry;
        flags.v = overflow;
    end

endmodule

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//
// EX->MEM pipeline register for the ALU result. Holds a head entry that
// drives the out_* ports and a skid entry that absorbs one extra entry when
// MEM stalls, so in_ready can be a flop and MEM back-pressure never reaches
// the EX stage combinationally. Also owns the architectural NZCV register,
// which is written when a flag-setting entry leaves the stage.
//
// Parameters:
//   WIDTH        datapath width (default 64)
//   REG_ADDR_W   destination register tag width (default 5)
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   flush                          synchronous kill of both stored entries
//   in_valid / in_ready            EX-side handshake (in_ready registered)
//   in_result, in_carry,
//   in_overflow, in_set_flags,
//   in_rd, in_reg_write            incoming entry fields
//   out_valid / out_ready          MEM-side handshake (out_valid registered)
//   out_result, out_rd,
//   out_reg_write                  head entry fields
//   flag_n, flag_z, flag_c, flag_v architectural flags
//   stall_cycles                   only with ALU_STAGE_PERF_EN defined:
//                                  saturating count of cycles with
//                                  out_valid & !out_ready
//
// Build option:
//   ALU_STAGE_PERF_EN  adds the stall_cycles port and counter.
// ---------------------------------------------------------------------------
module alu_result_stage #(
    parameter int WIDTH      = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_result,
    input  logic                  in_carry,
    input  logic                  in_overflow,
    input  logic                  in_set_flags,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,

`ifdef ALU_STAGE_PERF_EN
    output logic [31:0]           stall_cycles,
`endif
    output logic                  flag_n,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  flag_v
);

    import cpu_pipe_pkg::*;

    // Same field order as cpu_pipe_pkg::alu_entry_t, sized to this instance.
    typedef struct packed {
        logic [WIDTH-1:0]      result;
        logic                  carry;
        logic                  overflow;
        logic                  set_flags;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  valid;
    } entry_t;

    entry_t head_q;
    entry_t head_d;
    entry_t skid_q;
    entry_t skid_d;
    entry_t in_entry;

    logic   in_ready_q;
    logic   in_xfer;
    logic   out_xfer;
    logic   flag_commit;

    flags_t flags_q;
    flags_t head_flags;

    // Incoming entry as it would be stored in either slot.
    always_comb begin
        in_entry           = '0;
        in_entry.result    = in_result;
        in_entry.carry     = in_carry;
        in_entry.overflow  = in_overflow;
        in_entry.set_flags = in_set_flags;
        in_entry.rd        = in_rd;
        in_entry.reg_write = in_reg_write;
        in_entry.valid     = 1'b1;
    end

    // in_valid is ignored while flushing so a flush always leaves the
    // stage empty. An output handshake in the flush cycle still counts.
    assign in_xfer     = in_valid & in_ready_q & ~flush;
    assign out_xfer    = head_q.valid & out_ready;
    assign flag_commit = out_xfer & head_q.set_flags;

    // Flags for whatever sits in the head; only used when it leaves.
    flag_calc #(
        .WIDTH (WIDTH)
    ) u_flag_calc (
        .result   (head_q.result),
        .carry    (head_q.carry),
        .overflow (head_q.overflow),
        .flags    (head_flags)
    );

    // Next-state selection for the head and skid slots. Emptying a slot
    // clears only its valid bit so out_result/out_rd stay stable while the
    // stage is empty. A full skid implies in_ready is low, so no new entry
    // can collide with the skid moving into the head.
    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        if (flush) begin
            head_d.valid = 1'b0;
            skid_d.valid = 1'b0;
        end else if (out_xfer) begin
            if (skid_q.valid) begin
                head_d       = skid_q;
                skid_d.valid = 1'b0;
            end else if (in_xfer) begin
                head_d = in_entry;
            end else begin
                head_d.valid = 1'b0;
            end
        end else if (in_xfer) begin
            if (!head_q.valid) begin
                head_d = in_entry;
            end else begin
                skid_d = in_entry;
            end
        end
    end

    // Storage, registered in_ready and the flag register. in_ready simply
    // mirrors "skid will be empty", which is what keeps it a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            flags_q    <= FLAGS_RESET;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= ~skid_d.valid;
            if (flag_commit) begin
                flags_q <= head_flags;
            end
        end
    end

`ifdef ALU_STAGE_PERF_EN
    logic [31:0] stall_q;

    // Cycles where MEM refuses a valid head. Deliberately not cleared by
    // flush so the count covers the whole run; it sticks at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (head_q.valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign in_ready      = in_ready_q;
    assign out_valid     = head_q.valid;
    assign out_result    = head_q.result;
    assign out_rd        = head_q.rd;
    assign out_reg_write = head_q.reg_write;

    assign flag_n = flags_q.n;
    assign flag_z = flags_q.z;
    assign flag_c = flags_q.c;
    assign flag_v = flags_q.v;

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
//
// Directed bench for alu_result_stage. A 64-bit instance is checked every
// cycle against a queue-based model; a 32-bit instance covers the narrow
// width corner. Build option ALU_STAGE_PERF_EN also checks stall_cycles.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_result = '0;
    logic        in_carry = 1'b0;
    logic        in_overflow = 1'b0;
    logic        in_set_flags = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        in_reg_write = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        flag_n, flag_z, flag_c, flag_v;

    logic        s_in_valid = 1'b0;
    logic [31:0] s_in_result = '0;
    logic        s_in_carry = 1'b0;
    logic        s_in_overflow = 1'b0;
    logic        s_in_set_flags = 1'b0;
    logic        s_out_ready = 1'b1;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_result;
    logic [4:0]  s_out_rd;
    logic        s_out_reg_write;
    logic        s_flag_n, s_flag_z, s_flag_c, s_flag_v;

`ifdef ALU_STAGE_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] s_stall_cycles;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(64), .REG_ADDR_W(5)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_carry      (in_carry),
        .in_overflow   (in_overflow),
        .in_set_flags  (in_set_flags),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
`ifdef ALU_STAGE_PERF_EN
        .stall_cycles  (stall_cycles),
`endif
        .flag_n        (flag_n),
        .flag_z        (flag_z),
        .flag_c        (flag_c),
        .flag_v        (flag_v)
    );

    alu_result_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut32 (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (1'b0),
        .in_valid      (s_in_valid),
        .in_ready      (s_in_ready),
        .in_result     (s_in_result),
        .in_carry      (s_in_carry),
        .in_overflow   (s_in_overflow),
        .in_set_flags  (s_in_set_flags),
        .in_rd         (5'd3),
        .in_reg_write  (1'b1),
        .out_valid     (s_out_valid),
        .out_ready     (s_out_ready),
        .out_result    (s_out_result),
        .out_rd        (s_out_rd),
        .out_reg_write (s_out_reg_write),
`ifdef ALU_STAGE_PERF_EN
        .stall_cycles  (s_stall_cycles),
`endif
        .flag_n        (s_flag_n),
        .flag_z        (s_flag_z),
        .flag_c        (s_flag_c),
        .flag_v        (s_flag_v)
    );

    // Reference model: the stage is a FIFO of at most two entries whose
    // front is what MEM sees. Flags are recomputed from first principles.
    typedef struct {
        logic [63:0] result;
        logic        carry;
        logic        overflow;
        logic        set_flags;
        logic [4:0]  rd;
        logic        reg_write;
    } m_entry_t;

    m_entry_t    m_q[$];
    logic [3:0]  m_flags = 4'b0000;
    logic        m_in_ready = 1'b1;
    logic [31:0] m_stall = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_flags    = 4'b0000;
            m_in_ready = 1'b1;
            m_stall    = '0;
        end else begin
            m_entry_t e;
            bit       took_in;
            took_in = in_valid && m_in_ready && !flush;
            if (m_q.size() > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) begin
                m_stall = m_stall + 1;
            end
            if (m_q.size() > 0 && out_ready) begin
                e = m_q.pop_front();
                if (e.set_flags) begin
                    m_flags = {e.result[63], (e.result == 64'd0), e.carry, e.overflow};
                end
            end
            if (flush) begin
                m_q.delete();
            end else if (took_in) begin
                e.result    = in_result;
                e.carry     = in_carry;
                e.overflow  = in_overflow;
                e.set_flags = in_set_flags;
                e.rd        = in_rd;
                e.reg_write = in_reg_write;
                m_q.push_back(e);
            end
            m_in_ready = (m_q.size() < 2);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Every falling edge: DUT outputs against the model.
    always @(negedge clk) begin
        checkOutput("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
        checkOutput("in_ready", 64'(in_ready), 64'(m_in_ready));
        checkOutput("flags", 64'({flag_n, flag_z, flag_c, flag_v}), 64'(m_flags));
        if (m_q.size() > 0) begin
            checkOutput("out_result", out_result, m_q[0].result);
            checkOutput("out_rd", 64'(out_rd), 64'(m_q[0].rd));
            checkOutput("out_reg_write", 64'(out_reg_write), 64'(m_q[0].reg_write));
        end
`ifdef ALU_STAGE_PERF_EN
        checkOutput("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
    end

    task automatic applyStimulus(input logic v, input logic [63:0] res,
                                 input logic c, input logic ov, input logic sf,
                                 input logic [4:0] rd, input logic rw);
        in_valid     = v;
        in_result    = res;
        in_carry     = c;
        in_overflow  = ov;
        in_set_flags = sf;
        in_rd        = rd;
        in_reg_write = rw;
    endtask

    function automatic logic [3:0] nzcv();
        return {flag_n, flag_z, flag_c, flag_v};
    endfunction

    initial begin
        // Reset held with a valid input present.
        #1 reset_n = 1'b0;
        applyStimulus(1'b1, 64'h77, 1'b1, 1'b1, 1'b1, 5'd1, 1'b1);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_flags", 64'(nzcv()), 64'h0);
        checkOutput("rst_out_result", out_result, 64'd0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 64'h5, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
        @(negedge clk);
        checkOutput("first_result", out_result, 64'h5);
        checkOutput("first_valid", 64'(out_valid), 64'd1);

        // Streaming: 8 back-to-back entries.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 64'(i), 1'b0, 1'b0, 1'b0, 5'(i), i[0]);
            @(negedge clk);
            checkOutput("stream_result", out_result, 64'(i));
            checkOutput("stream_in_ready", 64'(in_ready), 64'd1);
        end
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);

        // Back-pressure: A then B with MEM stalled.
        out_ready = 1'b0;
        applyStimulus(1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 5'd10, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 64'hB, 1'b0, 1'b0, 1'b0, 5'd11, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
        checkOutput("bp_head_a", out_result, 64'hA);
        @(negedge clk);
        checkOutput("bp_hold_a", out_result, 64'hA);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_head_b", out_result, 64'hB);
        checkOutput("bp_in_ready_back", 64'(in_ready), 64'd1);
        @(negedge clk);
        checkOutput("bp_empty", 64'(out_valid), 64'd0);

        // Flag commit sequence.
        applyStimulus(1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1);
        @(negedge clk);
        checkOutput("flags_before", 64'(nzcv()), 64'h0);
        applyStimulus(1'b1, 64'h0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1);
        @(negedge clk);
        checkOutput("flags_1011", 64'(nzcv()), 64'hB);
        applyStimulus(1'b1, 64'h0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1);
        @(negedge clk);
        checkOutput("flags_hold", 64'(nzcv()), 64'hB);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        checkOutput("flags_0100", 64'(nzcv()), 64'h4);

        // Flush with a full buffer, MEM stalled: no flag commit.
        out_ready = 1'b0;
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 64'h1B, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1);
        @(negedge clk);
        checkOutput("fl_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        applyStimulus(1'b1, 64'hC, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("fl_out_valid", 64'(out_valid), 64'd0);
        checkOutput("fl_in_ready", 64'(in_ready), 64'd1);
        checkOutput("fl_flags_held", 64'(nzcv()), 64'h4);
        @(negedge clk);

        // Same, but the head handshakes in the flush cycle: A's flags commit.
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 64'h1B, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flx_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flx_flags_1001", 64'(nzcv()), 64'h9);

        // Mixed traffic with irregular stalls and one flush.
        for (int c = 0; c < 60; c++) begin
            out_ready = ((c % 3) != 1);
            flush     = (c == 37);
            applyStimulus((c % 4) != 3,
                          64'(c) * 64'h0101_0101_0101_0101 ^ ((c > 30) ? 64'h8000_0000_0000_0000 : 64'h0),
                          (c % 5) == 0, (c % 7) == 0, c[0], 5'(c), c[1]);
            @(negedge clk);
        end
        flush = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        repeat (3) @(negedge clk);

        // 32-bit instance: N comes from bit 31.
        s_in_valid     = 1'b1;
        s_in_result    = 32'hFFFF_FFFF;
        s_in_set_flags = 1'b1;
        @(negedge clk);
        checkOutput("w32_result", 64'(s_out_result), 64'hFFFF_FFFF);
        s_in_result = 32'h0;
        @(negedge clk);
        checkOutput("w32_flags_n", 64'({s_flag_n, s_flag_z, s_flag_c, s_flag_v}), 64'h8);
        s_in_valid = 1'b0;
        @(negedge clk);
        checkOutput("w32_flags_z", 64'({s_flag_n, s_flag_z, s_flag_c, s_flag_v}), 64'h4);
        checkOutput("w32_empty", 64'(s_out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
